// File: rtl/sd_pack_pkg.sv
// Shared types and constants for the SD BMP pixel packer.
package sd_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIX  = 2'd2,
    DONE = 2'd3
  } sd_state_e;

  // Word position inside a 3-word / 2-pixel group
  typedef logic [1:0] phase_t;

  localparam int BMP_HDR_WORDS   = 27;
  localparam int FRAME_PIX_1080P = 2073600;
  localparam int PIX_CNT_W       = 22;

endpackage

// File: rtl/sd_bmp_pixel_pack_if.sv
// Word-in / pixel-out bus of the BMP pixel packer.
interface sd_bmp_pixel_pack_if;
  logic                               frame_start;
  logic                               in_valid;
  logic [15:0]                        in_data;
  logic                               out_valid;
  logic [23:0]                        out_data;
  logic                               frame_done;
  logic [sd_pack_pkg::PIX_CNT_W-1:0]  pix_cnt;
  logic                               busy;

  modport slave (
    input  frame_start, in_valid, in_data,
    output out_valid, out_data, frame_done, pix_cnt, busy
  );

  modport master (
    output frame_start, in_valid, in_data,
    input  out_valid, out_data, frame_done, pix_cnt, busy
  );
endinterface

// File: rtl/sd_bmp_lane_merge.sv
// Builds one {R,G,B} pixel from the current word and the latched previous word.
module sd_bmp_lane_merge
  import sd_pack_pkg::*;
(
  input  logic [15:0] cur,
  input  logic [15:0] prev,
  input  phase_t      ph,
  output logic [23:0] pix
);

  // [15:8] of each word is the earlier byte on the card; BMP stores B,G,R
  always_comb begin
    pix = 24'h0;
    case (ph)
      2'd1:    pix = {cur[15:8], prev[7:0], prev[15:8]};
      2'd2:    pix = {cur[7:0], cur[15:8], prev[7:0]};
      default: pix = 24'h0;
    endcase
  end

endmodule

// File: rtl/sd_bmp_pixel_pack.sv
// Strips the BMP header from the SD word stream and packs 3 words into 2 RGB888 pixels.
// Define SD_PACK_BYTE_SWAP_EN when the upstream word has the earlier byte in [7:0].
module sd_bmp_pixel_pack
  import sd_pack_pkg::*;
#(
  parameter int HDR_WORDS     = BMP_HDR_WORDS,
  parameter int PIX_PER_FRAME = FRAME_PIX_1080P
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  sd_bmp_pixel_pack_if.slave  bus
);

  localparam logic [31:0]          HDR_LAST = 32'(HDR_WORDS);
  localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(PIX_PER_FRAME);

  sd_state_e   state;
  phase_t      ph;
  logic [31:0] hdr_cnt;
  logic [15:0] word;
  logic [15:0] prev;
  logic [23:0] pix;

`ifdef SD_PACK_BYTE_SWAP_EN
  assign word = {bus.in_data[7:0], bus.in_data[15:8]};
`else
  assign word = bus.in_data;
`endif

  sd_bmp_lane_merge u_merge (
    .cur  (word),
    .prev (prev),
    .ph   (ph),
    .pix  (pix)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= IDLE;
      ph             <= 2'd0;
      hdr_cnt        <= 32'd0;
      prev           <= 16'h0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= 24'h0;
      bus.frame_done <= 1'b0;
      bus.pix_cnt    <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      // A new picture wins over any word arriving in the same cycle
      if (bus.frame_start) begin
        hdr_cnt     <= 32'd0;
        bus.pix_cnt <= '0;
        ph          <= 2'd0;
        bus.busy    <= 1'b1;
        state       <= (HDR_WORDS == 0) ? PIX : HDR;
      end else if (bus.in_valid) begin
        case (state)
          HDR: begin
            hdr_cnt <= hdr_cnt + 32'd1;
            if (hdr_cnt + 32'd1 == HDR_LAST) state <= PIX;
          end
          PIX: begin
            prev <= word;
            ph   <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            if (ph != 2'd0) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= pix;
              bus.pix_cnt   <= bus.pix_cnt + 1'b1;
              if (bus.pix_cnt + 1'b1 == PIX_LAST) begin
                state          <= DONE;
                bus.frame_done <= 1'b1;
                bus.busy       <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_bmp_pixel_pack.sv
// Bench for sd_bmp_pixel_pack: vector table, corner sequences and a byte-queue reference model.
module tb_sd_bmp_pixel_pack;

  localparam int A_HDR = 2;
  localparam int A_PPF = 8;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  sd_bmp_pixel_pack_if ia();
  sd_bmp_pixel_pack_if ib();

  sd_bmp_pixel_pack #(.HDR_WORDS(A_HDR), .PIX_PER_FRAME(A_PPF)) dut_a (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (ia)
  );

  sd_bmp_pixel_pack #(.HDR_WORDS(0), .PIX_PER_FRAME(4)) dut_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (ib)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus words are written in card byte order; the swap build sees them little-endian
  function automatic logic [15:0] card(input logic [15:0] w);
`ifdef SD_PACK_BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for dut_a: skip header words, then every 3 card bytes form one pixel
  bit              m_act;
  int              m_hdr;
  int              m_npix;
  logic [7:0]      m_bytes[$];
  logic [23:0]     m_data;
  bit              m_ev;
  bit              m_fd;

  task automatic model_reset();
    m_act = 0; m_hdr = 0; m_npix = 0; m_bytes.delete(); m_data = 24'h0;
    m_ev = 0; m_fd = 0;
  endtask

  task automatic model_step(input bit fs, input bit v, input logic [15:0] w);
    m_ev = 0; m_fd = 0;
    if (fs) begin
      m_act = 1; m_hdr = 0; m_npix = 0; m_bytes.delete();
    end else if (v && m_act) begin
      if (m_hdr < A_HDR) m_hdr++;
      else begin
        m_bytes.push_back(w[15:8]);
        m_bytes.push_back(w[7:0]);
        if (m_bytes.size() >= 3) begin
          m_data = {m_bytes[2], m_bytes[1], m_bytes[0]};
          repeat (3) void'(m_bytes.pop_front());
          m_npix++;
          m_ev = 1;
          if (m_npix == A_PPF) begin m_fd = 1; m_act = 0; end
        end
      end
    end
  endtask

  // One cycle on dut_a: drive, clock, then compare every output against the model
  task automatic drive_a(input string nm, input bit fs, input bit v, input logic [15:0] w);
    ia.frame_start = fs;
    ia.in_valid    = v;
    ia.in_data     = card(w);
    if (sys_rst) model_reset();
    else model_step(fs, v, w);
    @(posedge sys_clk); #1;
    chk({nm, ".out_valid"},  32'(ia.out_valid),  32'(m_ev));
    chk({nm, ".out_data"},   32'(ia.out_data),   32'(m_data));
    chk({nm, ".frame_done"}, 32'(ia.frame_done), 32'(m_fd));
    chk({nm, ".pix_cnt"},    32'(ia.pix_cnt),    32'(m_npix));
    chk({nm, ".busy"},       32'(ia.busy),       32'(m_act));
  endtask

  task automatic drive_b(input bit fs, input bit v, input logic [15:0] w);
    ib.frame_start = fs;
    ib.in_valid    = v;
    ib.in_data     = card(w);
    @(posedge sys_clk); #1;
  endtask

  typedef struct {
    bit          fs;
    bit          v;
    logic [15:0] d;
    bit          ev;
    logic [23:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit fs, input bit v, input logic [15:0] d,
                              input bit ev, input logic [23:0] ed);
    vec_t t;
    t.fs = fs; t.v = v; t.d = d; t.ev = ev; t.ed = ed;
    tbl.push_back(t);
  endfunction

  typedef struct {
    logic [15:0] d;
    bit          ev;
    logic [23:0] ed;
    bit          fd;
  } bvec_t;

  bvec_t btbl[9];

  initial begin
    // Header skip, then the same pixel words at full rate and with 5-cycle gaps
    add(1, 0, 16'h0000, 0, 24'h000000);
    add(0, 1, 16'hAAAA, 0, 24'h000000);
    add(0, 1, 16'hBBBB, 0, 24'h000000);
    add(0, 1, 16'h0102, 0, 24'h000000);
    add(0, 1, 16'h0304, 1, 24'h030201);
    add(0, 1, 16'h0506, 1, 24'h060504);
    add(0, 1, 16'h0102, 0, 24'h060504);
    repeat (5) add(0, 0, 16'hDEAD, 0, 24'h060504);
    add(0, 1, 16'h0304, 1, 24'h030201);
    repeat (5) add(0, 0, 16'hBEEF, 0, 24'h030201);
    add(0, 1, 16'h0506, 1, 24'h060504);

    btbl[0] = '{16'h0102, 0, 24'h000000, 0};
    btbl[1] = '{16'h0304, 1, 24'h030201, 0};
    btbl[2] = '{16'h0506, 1, 24'h060504, 0};
    btbl[3] = '{16'h0708, 0, 24'h060504, 0};
    btbl[4] = '{16'h090A, 1, 24'h090807, 0};
    btbl[5] = '{16'h0B0C, 1, 24'h0C0B0A, 1};
    btbl[6] = '{16'hFFFF, 0, 24'h0C0B0A, 0};
    btbl[7] = '{16'hEEEE, 0, 24'h0C0B0A, 0};
    btbl[8] = '{16'hDDDD, 0, 24'h0C0B0A, 0};

    ia.frame_start = 0; ia.in_valid = 0; ia.in_data = 16'h0;
    ib.frame_start = 0; ib.in_valid = 0; ib.in_data = 16'h0;
    model_reset();

    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.a.out_valid", 32'(ia.out_valid), 0);
    chk("rst.a.out_data",  32'(ia.out_data),  0);
    chk("rst.a.busy",      32'(ia.busy),      0);
    chk("rst.a.pix_cnt",   32'(ia.pix_cnt),   0);
    chk("rst.b.frame_done",32'(ib.frame_done),0);
    sys_rst = 1'b0;

    drive_a("idle_word", 0, 1, 16'h1234);

    foreach (tbl[i]) begin
      drive_a($sformatf("tbl%0d", i), tbl[i].fs, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d.ev", i), 32'(ia.out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.ed", i), 32'(ia.out_data),  32'(tbl[i].ed));
    end

    // frame_start together with W1: no pixel, word discarded, next words are header
    drive_a("col.fs", 1, 0, 16'h0);
    drive_a("col.h0", 0, 1, 16'h5555);
    drive_a("col.h1", 0, 1, 16'h6666);
    drive_a("col.w0", 0, 1, 16'h1111);
    drive_a("col.hit", 1, 1, 16'h2222);
    chk("col.no_pixel", 32'(ia.out_valid), 0);
    chk("col.pix_cnt0", 32'(ia.pix_cnt),   0);
    drive_a("col.h2", 0, 1, 16'h3333);
    drive_a("col.h3", 0, 1, 16'h4444);
    drive_a("col.p0", 0, 1, 16'h0A0B);
    drive_a("col.p1", 0, 1, 16'h0C0D);
    chk("col.pixel", 32'(ia.out_data), 32'h0C0B0A);
    drive_a("col.p2", 0, 1, 16'h0E0F);
    chk("col.pixel2", 32'(ia.out_data), 32'h0F0E0D);

    // Reset arriving with W2: no pixel, all outputs back to zero
    drive_a("rs.fs", 1, 0, 16'h0);
    drive_a("rs.h0", 0, 1, 16'h9999);
    drive_a("rs.h1", 0, 1, 16'h8888);
    drive_a("rs.w0", 0, 1, 16'h0102);
    drive_a("rs.w1", 0, 1, 16'h0304);
    sys_rst = 1'b1;
    drive_a("rs.w2", 0, 1, 16'h0506);
    sys_rst = 1'b0;
    chk("rs.out_valid", 32'(ia.out_valid), 0);
    chk("rs.out_data",  32'(ia.out_data),  0);
    chk("rs.busy",      32'(ia.busy),      0);
    drive_a("rs.after", 0, 1, 16'h0708);
    chk("rs.idle_ignore", 32'(ia.out_valid), 0);

    // Randomized frames with random gaps against the byte-queue model
    for (int f = 0; f < 8; f++) begin
      drive_a($sformatf("rnd%0d.fs", f), 1, 0, 16'h0);
      for (int k = 0, n = $urandom_range(8, 24); k < n; k++) begin
        repeat ($urandom_range(0, 2)) drive_a($sformatf("rnd%0d.gap", f), 0, 0, 16'($urandom));
        drive_a($sformatf("rnd%0d.w%0d", f, k), 0, 1, 16'($urandom));
      end
    end

    // Frame end on dut_b (no header, 4 pixels)
    drive_b(1, 0, 16'h0);
    chk("fe.busy_start", 32'(ib.busy), 1);
    for (int i = 0; i < 9; i++) begin
      drive_b(0, 1, btbl[i].d);
      chk($sformatf("fe%0d.out_valid", i),  32'(ib.out_valid),  32'(btbl[i].ev));
      chk($sformatf("fe%0d.out_data", i),   32'(ib.out_data),   32'(btbl[i].ed));
      chk($sformatf("fe%0d.frame_done", i), 32'(ib.frame_done), 32'(btbl[i].fd));
    end
    drive_b(0, 0, 16'h0);
    chk("fe.busy_done", 32'(ib.busy),    0);
    chk("fe.pix_cnt",   32'(ib.pix_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_bmp_pixel_pack.md
# sd_bmp_pixel_pack

Converts the SD-card read stream (16-bit words, raw 24-bit BMP bytes) into 24-bit RGB888 pixels for the SDRAM write port. It sits directly downstream of `sd_ctrl` (`rd_data_en`/`rd_data`) and upstream of the `sdram_top` write FIFO. Per picture, it strips the BMP file header, repacks every three 16-bit words into two pixels, and reorders BMP B,G,R bytes into {R,G,B}. It counts pixels and flags when a full frame has been written.

## Interface
Parameters:
- `HDR_WORDS`, default 27 — header length in 16-bit words (54-byte BMP header); 0 is legal.
- `PIX_PER_FRAME`, default 2073600 — pixels per picture (1920×1080); must be at least 2 and even.

Ports:
- `sys_clk`  in  1  — single clock, 50 MHz SD domain.
- `sys_rst`  in  1  — reset; synchronous, active-high.
- `frame_start`  in  1  — one-cycle pulse; begins a new picture (clears counters and phase).
- `in_valid`  in  1  — word strobe, from `sd_ctrl.rd_data_en`.
- `in_data`  in  16  — word; `[15:8]` is the earlier byte on the card.
- `out_valid`  out  1  — pixel strobe, to the write FIFO `wr_req`.
- `out_data`  out  24  — pixel `{R[7:0],G[7:0],B[7:0]}`.
- `frame_done`  out  1  — one-cycle pulse after the last pixel of a picture.
- `pix_cnt`  out  22  — pixels emitted in the current picture.
- `busy`  out  1  — high in HDR or PIX.

## Operation
- FSM states: IDLE, HDR, PIX, DONE. The reset state is IDLE.
- `frame_start` in any state:
  - clears the header counter, pixel counter and phase;
  - goes to HDR, or to PIX if `HDR_WORDS==0`;
  - any `in_valid` word in the same cycle is discarded.
- HDR: each `in_valid` increments `hdr_cnt`. The word that makes `hdr_cnt==HDR_WORDS` is the last header word; the next state is PIX. Header words never produce output.
- PIX uses a 3-phase word counter, `ph` = 0, 1, 2. Words W0, W1, W2 carry bytes b0..b5.
  - ph0: latch W0; no output.
  - ph1: emit pixel0 = `{W1[15:8], W0[7:0], W0[15:8]}` (R=b2, G=b1, B=b0). Latch W1.
  - ph2: emit pixel1 = `{W2[7:0], W2[15:8], W1[7:0]}` (R=b5, G=b4, B=b3). `ph` returns to 0.
- Each emitted pixel increments `pix_cnt`. When the emitted pixel makes `pix_cnt==PIX_PER_FRAME`, go to DONE and pulse `frame_done` together with that `out_valid`.
- DONE: `in_valid` is ignored and `busy=0`. The block stays in DONE until `frame_start`.
- IDLE: `in_valid` is ignored.
- There is no backpressure. The downstream FIFO must absorb 2 pixels per 3 words.
- `pix_cnt` holds its final value in DONE and clears only on `frame_start` or reset.

## Timing
- Output latency: `out_valid`/`out_data` are registered and appear one cycle after the `in_valid` of the completing word (ph1 or ph2).
- Consecutive `in_valid` cycles are supported at full rate. Pixel output pattern: none, pixel, pixel, repeating.
- Gaps in `in_valid` of any length leave the phase and the latched bytes untouched.
- Reset values:
  - `out_valid=0`, `out_data=0`, `frame_done=0`, `pix_cnt=0`, `busy=0`;
  - state IDLE, `ph=0`, `hdr_cnt=0`.
- Reset mid-picture: everything returns to reset values on the next edge. No partial pixel is emitted.
- Header-to-pixel boundary: the word after the last header word is W0 (ph0). There is no idle cycle requirement.
- `out_data` holds its last value when `out_valid=0`.

## Configuration
- `SD_PACK_BYTE_SWAP_EN`:
  - Defined: the two bytes of `in_data` are swapped at the input, so `[7:0]` is the earlier byte. This covers `sd_ctrl` builds that assemble words little-endian. The header count is unaffected.
  - Undefined: `[15:8]` is the earlier byte, as described above.

## Structure
- Shared package `sd_pack_pkg` holds:
  - the state enum (IDLE/HDR/PIX/DONE);
  - the phase type (2-bit);
  - the constants `BMP_HDR_WORDS=27` and `FRAME_PIX_1080P=2073600`.
- One natural sub-module, `sd_bmp_lane_merge`: the combinational selector that builds the 24-bit pixel from the current word, the latched previous word and `ph`. It is kept separate so its byte ordering can be checked alone.

## Test plan
- Header skip:
  - Stimulus: `HDR_WORDS=2`, `frame_start`, then words 0xAAAA, 0xBBBB, 0x0102, 0x0304, 0x0506.
  - Required response: pixels 0x030201 then 0x060504, with no output during the header.
- Full rate vs gaps:
  - Stimulus: the same three pixel words sent back-to-back, then with 5-cycle gaps between words.
  - Required response: identical output data in both cases. Each `out_valid` comes exactly 1 cycle after its W1/W2 strobe.
- Frame end:
  - Stimulus: `PIX_PER_FRAME=4`, `HDR_WORDS=0`, then 9 words.
  - Required response:
    - 4 pixels are emitted, and `frame_done` pulses with the 4th;
    - words 7–9 are ignored, `busy=0` and `pix_cnt=4`.
- `frame_start` collision:
  - Stimulus: assert `frame_start` in ph1 together with `in_valid`.
  - Required response: no pixel is emitted and `pix_cnt=0`. The next word is treated as a header word.
- Reset mid-operation:
  - Stimulus: assert `sys_rst` in ph2 with `in_valid`.
  - Required response: no `out_valid` follows, and all outputs are 0 on the next cycle.
- Byte swap:
  - Stimulus: with `SD_PACK_BYTE_SWAP_EN` defined, words 0x0201, 0x0403, 0x0605.
  - Required response: pixels 0x030201 then 0x060504.
